dreg_port_arb: RTL and testbench

//  Shares the data register file's single read port and single write port among
//  NRD read requesters (operand A, operand B, debug) and two write requesters
//  (0 = writeback, 1 = debug). Reads use round-robin arbitration and writes use

---
 rtl/dreg_port_arb.sv | 84 ++++++++
 tb/tb_dreg_port_arb.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dreg_port_arb.sv
// dreg_port_arb: shares one register-file read port (round robin, registered
// response with write forwarding) and one write port (fixed priority with a
// starvation guard for port 1) among several requesters.
//   rd_req/rd_addr -> rd_gnt, rf_ra ; rsp_valid/rsp_id/rsp_data one cycle later
//   wr_req/wr_addr/wr_data -> wr_gnt, rf_w/rf_wa/rf_wval ; rf_rval from the file
module dreg_port_arb #(
  parameter int WIDTH   = 32,
  parameter int NRD     = 3,
  parameter int MAXWAIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NRD-1:0]     rd_req,
  input  logic [5*NRD-1:0]   rd_addr,
  output logic [NRD-1:0]     rd_gnt,
  output logic               rsp_valid,
  output logic [2:0]         rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  input  logic [1:0]         wr_req,
  input  logic [9:0]         wr_addr,
  input  logic [2*WIDTH-1:0] wr_data,
  output logic [1:0]         wr_gnt,
  output logic [4:0]         rf_ra,
  input  logic [WIDTH-1:0]   rf_rval,
  output logic               rf_w,
  output logic [4:0]         rf_wa,
  output logic [WIDTH-1:0]   rf_wval
);
  localparam int IW = $clog2(NRD);
  localparam int SW = $clog2(MAXWAIT + 1);
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d, gnt_idx;
  logic             rd_hit, force1, fwd;
  logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
  logic             rsp_valid_q;
  logic [2:0]       rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  always_comb begin
    rd_hit  = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NRD; k++)
      if (!rd_hit && rd_req[IW'((int'(rr_ptr_q) + k) % NRD)]) begin
        rd_hit  = 1'b1;
        gnt_idx = IW'((int'(rr_ptr_q) + k) % NRD);
      end
    rd_hit = rd_hit & rst_n;
    rd_gnt = rd_hit ? NRD'(1) << gnt_idx : '0;
    rf_ra  = '0;
    for (int i = 0; i < NRD; i++)
      rf_ra = rf_ra | (rd_gnt[i] ? rd_addr[5*i +: 5] : 5'd0);
  end
  assign rr_ptr_d = rd_hit ? gnt_idx : rr_ptr_q;
  // port 1 also wins outright whenever port 0 is idle
  assign force1  = wr_req[1] && starve_cnt_q == SW'(MAXWAIT);
  assign wr_gnt  = !rst_n ? 2'b00 : (force1 || (wr_req[1] && !wr_req[0])) ? 2'b10 : {1'b0, wr_req[0]};
  assign rf_w    = |wr_gnt;
  assign rf_wa   = wr_gnt[1] ? wr_addr[9:5] : wr_gnt[0] ? wr_addr[4:0] : 5'd0;
  assign rf_wval = wr_gnt[1] ? wr_data[2*WIDTH-1:WIDTH] : wr_gnt[0] ? wr_data[WIDTH-1:0] : '0;
  assign starve_cnt_d = (wr_req[1] && !wr_gnt[1])
                        ? (starve_cnt_q == SW'(MAXWAIT) ? starve_cnt_q : starve_cnt_q + 1'b1)
                        : '0;
  // low-half writes are mirrored into the high half, never the other way round
  assign fwd        = rf_w && (rf_wa == rf_ra || (!rf_wa[4] && {1'b1, rf_wa[3:0]} == rf_ra));
  assign rsp_data_d = fwd ? rf_wval : rf_rval;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= IW'(NRD - 1);
      starve_cnt_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      rsp_valid_q  <= rd_hit;
      if (rd_hit) begin
        rsp_id_q   <= 3'(gnt_idx);
        rsp_data_q <= rsp_data_d;
      end
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_dreg_port_arb.sv
// tb_dreg_port_arb: directed and randomized bench for dreg_port_arb with a behavioural model.
module tb_dreg_port_arb;
  localparam int WIDTH = 32, NRD = 3, MAXWAIT = 4;
  logic clk = 0, rst_n;
  logic [NRD-1:0] rd_req, rd_gnt;
  logic [5*NRD-1:0] rd_addr;
  logic rsp_valid, rf_w;
  logic [2:0] rsp_id;
  logic [WIDTH-1:0] rsp_data, rf_rval, rf_wval;
  logic [1:0] wr_req, wr_gnt;
  logic [9:0] wr_addr;
  logic [2*WIDTH-1:0] wr_data;
  logic [4:0] rf_ra, rf_wa;
  logic [WIDTH-1:0] rf [32];
  int checks = 0, failures = 0;
  int ptr, stv, ev, eid, er, ew;
  logic [WIDTH-1:0] ed;
  logic [NRD-1:0] last_rg;
  logic [1:0] last_wg;
  dreg_port_arb #(.WIDTH(WIDTH), .NRD(NRD), .MAXWAIT(MAXWAIT)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt), .rf_ra(rf_ra), .rf_rval(rf_rval),
    .rf_w(rf_w), .rf_wa(rf_wa), .rf_wval(rf_wval));
  always #5 clk = ~clk;
  assign rf_rval = rf[rf_ra];
  always @(posedge clk)
    if (rf_w) begin
      rf[rf_wa] <= rf_wval;
      if (rf_wa < 16) rf[rf_wa + 16] <= rf_wval;
    end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  // behavioural model: register file contents after the write decide the read value
  initial begin
    logic [WIDTH-1:0] t [32];
    logic [4:0] era, ewa;
    logic [WIDTH-1:0] ewv;
    ptr = NRD - 1; stv = 0; ev = 0; eid = 0; ed = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("m_rst_rd_gnt", rd_gnt, 0);
        chk("m_rst_wr_gnt", wr_gnt, 0);
        chk("m_rst_rf_w", rf_w, 0);
        chk("m_rst_rsp_valid", rsp_valid, 0);
        chk("m_rst_rsp_id", rsp_id, 0);
        chk("m_rst_rsp_data", rsp_data, 0);
        ptr = NRD - 1; stv = 0; ev = 0; eid = 0; ed = '0;
      end else begin
        chk("m_rsp_valid", rsp_valid, ev);
        chk("m_rsp_id", rsp_id, eid);
        chk("m_rsp_data", rsp_data, ed);
        er = -1;
        for (int k = 1; k <= NRD; k++)
          if (er < 0 && rd_req[(ptr + k) % NRD]) er = (ptr + k) % NRD;
        ew = (wr_req[1] && stv == MAXWAIT) ? 1 : wr_req[0] ? 0 : wr_req[1] ? 1 : -1;
        era = er < 0 ? 5'd0 : 5'(rd_addr >> (5 * er));
        ewa = ew < 0 ? 5'd0 : 5'(wr_addr >> (5 * ew));
        ewv = ew < 0 ? '0 : WIDTH'(wr_data >> (WIDTH * ew));
        chk("m_rd_gnt", rd_gnt, er < 0 ? 0 : 1 << er);
        chk("m_rf_ra", rf_ra, era);
        chk("m_wr_gnt", wr_gnt, ew < 0 ? 0 : 1 << ew);
        chk("m_rf_w", rf_w, ew >= 0);
        chk("m_rf_wa", rf_wa, ewa);
        chk("m_rf_wval", rf_wval, ewv);
        t = rf;
        if (ew >= 0) begin
          t[ewa] = ewv;
          if (ewa < 16) t[ewa + 16] = ewv;
        end
        ev = er >= 0;
        if (er >= 0) begin
          eid = er; ed = t[era]; ptr = er;
        end
        stv = (wr_req[1] && ew != 1) ? (stv < MAXWAIT ? stv + 1 : MAXWAIT) : 0;
      end
    end
  end
  initial begin
    logic [2:0] seq [6];
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst_n = 0; rd_req = '1; wr_req = '1; rd_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("t1_rd_gnt", rd_gnt, 0); chk("t1_wr_gnt", wr_gnt, 0);
    chk("t1_rf_w", rf_w, 0); chk("t1_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1; rd_req = '0; wr_req = '0;
    @(negedge clk);
    rd_req = 3'b111; rd_addr = {5'd7, 5'd6, 5'd5};
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("t2_rd_gnt", rd_gnt, seq[c]);
      if (c > 0) begin
        chk("t2_rsp_id", rsp_id, (c - 1) % 3);
        chk("t2_rsp_valid", rsp_valid, 1);
      end
      @(negedge clk);
    end
    rd_req = '0;
    #1 chk("t2_rsp_id_last", rsp_id, 2);
    @(negedge clk);
    wr_req = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'hDEADBEEF};
    rd_req = 3'b010; rd_addr = {5'd0, 5'd19, 5'd0};
    #1 chk("t3_rd_gnt", rd_gnt, 3'b010);
    chk("t3_wr_gnt", wr_gnt, 2'b01);
    @(negedge clk);
    rd_req = '0; wr_req = '0;
    #1 chk("t3_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("t3_rsp_id", rsp_id, 1);
    @(negedge clk);
    wr_req = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'hAAAA};
    @(negedge clk);
    wr_addr = {5'd0, 5'd20}; wr_data = {32'h0, 32'h1234};
    rd_req = 3'b001; rd_addr = {5'd0, 5'd0, 5'd4};
    @(negedge clk);
    wr_req = '0; rd_req = 3'b100; rd_addr = {5'd20, 5'd0, 5'd0};
    #1 chk("t4_rsp_low", rsp_data, 32'hAAAA);
    @(negedge clk);
    rd_req = '0;
    #1 chk("t4_rsp_high", rsp_data, 32'h1234);
    chk("t4_rsp_id", rsp_id, 2);
    @(negedge clk);
    wr_req = 2'b11; wr_addr = {5'd9, 5'd8}; wr_data = {32'h22, 32'h11};
    for (int c = 0; c < 6; c++) begin
      #1 chk("t5_wr_gnt", wr_gnt, c == 4 ? 2'b10 : 2'b01);
      @(negedge clk);
    end
    wr_req = '0;
    @(negedge clk);
    rd_req = 3'b100; rd_addr = {5'd1, 5'd0, 5'd0};
    #1 chk("t6_rd_gnt", rd_gnt, 3'b100);
    #2 rst_n = 0; rd_req = '0;
    @(negedge clk);
    #1 chk("t6_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1; rd_req = 3'b111;
    #1 chk("t6_first_gnt", rd_gnt, 3'b001);
    last_rg = rd_gnt; last_wg = wr_gnt;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < NRD; i++) begin
        if (rd_req[i] && last_rg[i]) rd_req[i] = 0;
        if (!rd_req[i] && $urandom_range(0, 2) == 0) begin
          rd_req[i] = 1; rd_addr[5*i +: 5] = 5'($urandom);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (wr_req[p] && last_wg[p]) wr_req[p] = 0;
        if (!wr_req[p] && $urandom_range(0, 3) != 0) begin
          wr_req[p] = 1; wr_addr[5*p +: 5] = 5'($urandom); wr_data[WIDTH*p +: WIDTH] = $urandom;
        end
      end
      #1 last_rg = rd_gnt; last_wg = wr_gnt;
    end
    @(negedge clk);
    rd_req = '0; wr_req = '0;
    repeat (2) @(negedge clk);
    #3 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
